gray_wptr_tx: RTL and testbench



---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray2bin.sv | 20 ++
 rtl/gray_wptr_tx.sv | 80 ++++++++
 tb/tb_gray_wptr_tx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers shared by the async FIFO pointer blocks.
package gray_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Pointer width carries one extra wrap bit above the RAM address.
    function automatic int unsigned ptr_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_word_t gray2bin(input gray_word_t g, input int unsigned w);
        gray_word_t b;
        logic       acc;
        b   = '0;
        acc = 1'b0;
        for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
            if (i < int'(w)) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic acc;

    always_comb begin
        bin_o = '0;
        acc   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/gray_wptr_tx.sv
// Write-side Gray pointer generator for an async FIFO: full, level and overflow.
// Optional almost_full_o output enabled by GRAY_WPTR_TX_ALMOST_FULL_EN.
module gray_wptr_tx
    import gray_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4
`ifdef GRAY_WPTR_TX_ALMOST_FULL_EN
  , parameter int unsigned AF_LEVEL = (2 ** ADDR_W) - 1
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic [ADDR_W:0]   rptr_gray_sync_i,
    output logic [ADDR_W:0]   wptr_gray_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              ovf_o
`ifdef GRAY_WPTR_TX_ALMOST_FULL_EN
  , output logic              almost_full_o
`endif
);

    localparam int unsigned PTR_W = ptr_width(ADDR_W);
    // Full when the write Gray pointer equals the read one with the top two bits flipped.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] wbin_q;
    logic [PTR_W-1:0] rbin_c;
    logic [PTR_W-1:0] wbin_next_c;
    logic [PTR_W-1:0] wgray_next_c;
    logic [PTR_W-1:0] level_next_c;
    logic             acc_c;
    logic             full_next_c;

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray_i (rptr_gray_sync_i),
        .bin_o  (rbin_c)
    );

    always_comb begin
        acc_c        = inc_i && !full_o;
        wbin_next_c  = wbin_q + PTR_W'(acc_c);
        wgray_next_c = PTR_W'(bin2gray(gray_word_t'(wbin_next_c)));
        full_next_c  = (wgray_next_c == (rptr_gray_sync_i ^ FULL_MASK));
        level_next_c = wbin_next_c - rbin_c;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbin_q      <= '0;
            wptr_gray_o <= '0;
            full_o      <= 1'b0;
            level_o     <= '0;
            ovf_o       <= 1'b0;
        end else begin
            wbin_q      <= wbin_next_c;
            wptr_gray_o <= wgray_next_c;
            full_o      <= full_next_c;
            level_o     <= level_next_c;
            ovf_o       <= inc_i && full_o;
        end
    end

    assign waddr_o = wbin_q[ADDR_W-1:0];

`ifdef GRAY_WPTR_TX_ALMOST_FULL_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            almost_full_o <= 1'b0;
        end else begin
            almost_full_o <= (level_next_c >= PTR_W'(AF_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_gray_wptr_tx.sv
// Directed self-checking bench for gray_wptr_tx with ADDR_W=2 (3-bit pointers).
module tb_gray_wptr_tx;

    localparam int unsigned ADDR_W = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              inc_i;
    logic [ADDR_W:0]   rptr_gray_sync_i;
    logic [ADDR_W:0]   wptr_gray_o;
    logic [ADDR_W-1:0] waddr_o;
    logic              full_o;
    logic [ADDR_W:0]   level_o;
    logic              ovf_o;

    int vectors     = 0;
    int miscompares = 0;

    gray_wptr_tx #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .inc_i            (inc_i),
        .rptr_gray_sync_i (rptr_gray_sync_i),
        .wptr_gray_o      (wptr_gray_o),
        .waddr_o          (waddr_o),
        .full_o           (full_o),
        .level_o          (level_o),
        .ovf_o            (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [2:0] b2g(input int n);
        logic [2:0] b;
        b = 3'(n);
        return b ^ {1'b0, b[2:1]};
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        inc_i = 1'b1;
        rptr_gray_sync_i = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                rst_i = 1'b0;
                inc_i = 1'b0;
            end
            step();
            vectors++;
            if (wptr_gray_o !== 3'b000) begin miscompares++; $display("FAIL reset_gray[%0d]: got %b expected 000", k, wptr_gray_o); end
            vectors++;
            if (waddr_o !== 2'b00) begin miscompares++; $display("FAIL reset_waddr[%0d]: got %b expected 00", k, waddr_o); end
            vectors++;
            if ({full_o, ovf_o} !== 2'b00) begin miscompares++; $display("FAIL reset_flags[%0d]: got full=%b ovf=%b expected 0 0", k, full_o, ovf_o); end
            vectors++;
            if (level_o !== 3'd0) begin miscompares++; $display("FAIL reset_level[%0d]: got %0d expected 0", k, level_o); end
        end
    endtask

    task automatic test_fill();
        logic [2:0] exp_gray [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
        logic [1:0] exp_addr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       exp_full [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        rptr_gray_sync_i = 3'b000;
        inc_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if (wptr_gray_o !== exp_gray[k]) begin miscompares++; $display("FAIL fill_gray[%0d]: got %b expected %b", k, wptr_gray_o, exp_gray[k]); end
            vectors++;
            if (level_o !== 3'(k + 1)) begin miscompares++; $display("FAIL fill_level[%0d]: got %0d expected %0d", k, level_o, k + 1); end
            vectors++;
            if (full_o !== exp_full[k]) begin miscompares++; $display("FAIL fill_full[%0d]: got %b expected %b", k, full_o, exp_full[k]); end
            vectors++;
            if (waddr_o !== exp_addr[k]) begin miscompares++; $display("FAIL fill_waddr[%0d]: got %0d expected %0d", k, waddr_o, exp_addr[k]); end
            vectors++;
            if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL fill_ovf[%0d]: got %b expected 0", k, ovf_o); end
        end
    endtask

    task automatic test_overflow();
        inc_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (ovf_o !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse[%0d]: got %b expected 1", k, ovf_o); end
            vectors++;
            if (wptr_gray_o !== 3'b110) begin miscompares++; $display("FAIL ovf_gray[%0d]: got %b expected 110", k, wptr_gray_o); end
            vectors++;
            if (level_o !== 3'd4) begin miscompares++; $display("FAIL ovf_level[%0d]: got %0d expected 4", k, level_o); end
            vectors++;
            if (full_o !== 1'b1) begin miscompares++; $display("FAIL ovf_full[%0d]: got %b expected 1", k, full_o); end
        end
        inc_i = 1'b0;
        step();
        vectors++;
        if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", ovf_o); end
    endtask

    task automatic test_simultaneous();
        // Read pointer advances in the same cycle as a write that is still rejected.
        rptr_gray_sync_i = 3'b001;
        inc_i = 1'b1;
        step();
        vectors++;
        if (full_o !== 1'b0) begin miscompares++; $display("FAIL sim_full_drop: got %b expected 0", full_o); end
        vectors++;
        if (level_o !== 3'd3) begin miscompares++; $display("FAIL sim_level: got %0d expected 3", level_o); end
        vectors++;
        if (wptr_gray_o !== 3'b110) begin miscompares++; $display("FAIL sim_gray_hold: got %b expected 110", wptr_gray_o); end
        vectors++;
        if (ovf_o !== 1'b1) begin miscompares++; $display("FAIL sim_ovf: got %b expected 1", ovf_o); end
        step();
        inc_i = 1'b0;
        vectors++;
        if (wptr_gray_o !== 3'b111) begin miscompares++; $display("FAIL sim_gray_acc: got %b expected 111", wptr_gray_o); end
        vectors++;
        if (full_o !== 1'b1) begin miscompares++; $display("FAIL sim_full_again: got %b expected 1", full_o); end
        vectors++;
        if (level_o !== 3'd4) begin miscompares++; $display("FAIL sim_level_again: got %0d expected 4", level_o); end
        vectors++;
        if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL sim_ovf_clear: got %b expected 0", ovf_o); end
    endtask

    task automatic test_wrap();
        logic [2:0] prev;
        logic [2:0] diff;
        rst_i = 1'b1;
        inc_i = 1'b0;
        rptr_gray_sync_i = 3'b000;
        step();
        rst_i = 1'b0;
        prev = 3'b000;
        inc_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            // Read pointer trails the next write pointer by two entries.
            rptr_gray_sync_i = (k >= 2) ? b2g(k - 2) : 3'b000;
            step();
            vectors++;
            if (wptr_gray_o !== b2g(k)) begin miscompares++; $display("FAIL wrap_gray[%0d]: got %b expected %b", k, wptr_gray_o, b2g(k)); end
            vectors++;
            if (level_o !== ((k < 2) ? 3'(k) : 3'd2)) begin miscompares++; $display("FAIL wrap_level[%0d]: got %0d expected %0d", k, level_o, (k < 2) ? k : 2); end
            vectors++;
            if (full_o !== 1'b0) begin miscompares++; $display("FAIL wrap_full[%0d]: got %b expected 0", k, full_o); end
            diff = prev ^ wptr_gray_o;
            vectors++;
            if ($countones(diff) != 1) begin miscompares++; $display("FAIL wrap_hamming[%0d]: got %b -> %b expected one bit change", k, prev, wptr_gray_o); end
            if (k == 8) begin
                vectors++;
                if ({prev, wptr_gray_o} !== 6'b100_000) begin miscompares++; $display("FAIL wrap_point: got %b -> %b expected 100 -> 000", prev, wptr_gray_o); end
            end
            prev = wptr_gray_o;
        end
        inc_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_simultaneous();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
